// File: rtl/string_fifo_cmp_avalon.sv
// string_fifo_cmp_avalon: Avalon-MM slave with two word FIFOs (A, B) and a
// compare engine that pops A/B word pairs and reports the first differing
// byte index (bytes ordered MSB-first). Status, sticky flags, levels, irq.
module string_fifo_cmp_avalon #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_a_q [DEPTH];
  logic [DATA_W-1:0] mem_b_q [DEPTH];
  logic [AW:0]       wr_a_q, rd_a_q, wr_b_q, rd_b_q;
  logic              ovf_a_q, ovf_b_q, udf_a_q, udf_b_q, done_q, irq_en_q;
  logic              ovf_a_d, ovf_b_d, udf_a_d, udf_b_d, done_d;
  logic              res_eq_q, res_eq_d;
  logic [15:0]       res_idx_q, res_idx_d, cmp_cnt_q, cmp_cnt_d;
  logic [31:0]       readdata_q, readdata_d;

  // Saturating 16-bit add for the byte index counter.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Bus decode and FIFO state.
  logic wr_s, rd_s, idle_s;
  logic push_a_s, push_b_s, pop_a_s, pop_b_s, ctrl_wr_s, stat_wr_s, go_s, clear_s;
  logic [AW:0] level_a_s, level_b_s;
  logic empty_a_s, empty_b_s, full_a_s, full_b_s;
  logic [DATA_W-1:0] word_a_s, word_b_s;

  assign wr_s      = chipselect & write;
  assign rd_s      = chipselect & read;
  assign idle_s    = (state_q == ST_IDLE);
  assign push_a_s  = wr_s && (address == 3'd0);
  assign push_b_s  = wr_s && (address == 3'd1);
  assign pop_a_s   = rd_s && (address == 3'd0);
  assign pop_b_s   = rd_s && (address == 3'd1);
  assign ctrl_wr_s = wr_s && (address == 3'd2);
  assign stat_wr_s = wr_s && (address == 3'd3);
  assign clear_s   = ctrl_wr_s & writedata[1];
  assign go_s      = ctrl_wr_s & writedata[0] & ~writedata[1];
  assign level_a_s = wr_a_q - rd_a_q;
  assign level_b_s = wr_b_q - rd_b_q;
  assign empty_a_s = (level_a_s == '0);
  assign empty_b_s = (level_b_s == '0);
  assign full_a_s  = (level_a_s == FULL_LVL);
  assign full_b_s  = (level_b_s == FULL_LVL);
  assign word_a_s  = mem_a_q[rd_a_q[AW-1:0]];
  assign word_b_s  = mem_b_q[rd_b_q[AW-1:0]];

  // First mismatching byte of the head pair; scanning down leaves the lowest index.
  logic        mismatch_s;
  logic [15:0] mm_idx_s;
  always_comb begin
    mismatch_s = 1'b0;
    mm_idx_s   = 16'd0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (word_a_s[DATA_W-1-8*k -: 8] != word_b_s[DATA_W-1-8*k -: 8]) begin
        mismatch_s = 1'b1;
        mm_idx_s   = 16'(k);
      end else begin
        mismatch_s = mismatch_s;
      end
    end
  end

  // Compare FSM next state, result and FIFO drain/pop controls.
  logic run_pop_s, drain_s;
  always_comb begin
    state_d   = state_q;
    cmp_cnt_d = cmp_cnt_q;
    res_eq_d  = res_eq_q;
    res_idx_d = res_idx_q;
    run_pop_s = 1'b0;
    drain_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          state_d   = ST_RUN;
          cmp_cnt_d = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (empty_a_s && empty_b_s) begin
          state_d   = ST_DONE;
          res_eq_d  = 1'b1;
          res_idx_d = cmp_cnt_q;
        end else if (empty_a_s || empty_b_s) begin
          // Leftover words in the longer string are discarded.
          state_d   = ST_DONE;
          res_eq_d  = 1'b0;
          res_idx_d = cmp_cnt_q;
          drain_s   = 1'b1;
        end else begin
          run_pop_s = 1'b1;
          if (mismatch_s) begin
            state_d   = ST_FLUSH;
            res_eq_d  = 1'b0;
            res_idx_d = sat_add(cmp_cnt_q, mm_idx_s);
          end else begin
            cmp_cnt_d = sat_add(cmp_cnt_q, 16'(NB));
          end
        end
      end
      ST_FLUSH: begin
        drain_s = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Clear aborts any run and leaves RESULT untouched.
    if (clear_s) begin
      state_d   = ST_IDLE;
      res_eq_d  = res_eq_q;
      res_idx_d = res_idx_q;
    end else begin
      state_d = state_d;
    end
  end

  // Sticky flags: FSM/host set has priority over write-1-to-clear.
  always_comb begin
    ovf_a_d = ovf_a_q;
    ovf_b_d = ovf_b_q;
    udf_a_d = udf_a_q;
    udf_b_d = udf_b_q;
    done_d  = done_q;
    if (clear_s) begin
      ovf_a_d = 1'b0;
      ovf_b_d = 1'b0;
      udf_a_d = 1'b0;
      udf_b_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      ovf_a_d = (push_a_s && (!idle_s || full_a_s))  | (ovf_a_q & ~(stat_wr_s & writedata[2]));
      ovf_b_d = (push_b_s && (!idle_s || full_b_s))  | (ovf_b_q & ~(stat_wr_s & writedata[3]));
      udf_a_d = (pop_a_s  && (!idle_s || empty_a_s)) | (udf_a_q & ~(stat_wr_s & writedata[4]));
      udf_b_d = (pop_b_s  && (!idle_s || empty_b_s)) | (udf_b_q & ~(stat_wr_s & writedata[5]));
      done_d  = (state_q == ST_DONE) | (done_q & ~(stat_wr_s & writedata[0]));
    end
  end

  // Read data mux; holds its value when no read is issued.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_s) begin
      case (address)
        3'd0:    readdata_d = (idle_s && !empty_a_s) ? 32'(word_a_s) : 32'd0;
        3'd1:    readdata_d = (idle_s && !empty_b_s) ? 32'(word_b_s) : 32'd0;
        3'd2:    readdata_d = {29'd0, irq_en_q, 2'b00};
        3'd3:    readdata_d = {8'd0, 8'(level_b_s), 8'(level_a_s), 2'b00,
                               udf_b_q, udf_a_q, ovf_b_q, ovf_a_q, !idle_s, done_q};
        3'd4:    readdata_d = {res_eq_q, 15'd0, res_idx_q};
        default: readdata_d = 32'd0;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  // Control/status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmp_cnt_q  <= 16'd0;
      res_eq_q   <= 1'b0;
      res_idx_q  <= 16'd0;
      ovf_a_q    <= 1'b0;
      ovf_b_q    <= 1'b0;
      udf_a_q    <= 1'b0;
      udf_b_q    <= 1'b0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cmp_cnt_q  <= cmp_cnt_d;
      res_eq_q   <= res_eq_d;
      res_idx_q  <= res_idx_d;
      ovf_a_q    <= ovf_a_d;
      ovf_b_q    <= ovf_b_d;
      udf_a_q    <= udf_a_d;
      udf_b_q    <= udf_b_d;
      done_q     <= done_d;
      irq_en_q   <= ctrl_wr_s ? writedata[2] : irq_en_q;
      readdata_q <= readdata_d;
    end
  end

  // FIFO pointers: clear, then engine drain/pop, then host access while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_a_q <= '0;
      rd_a_q <= '0;
      wr_b_q <= '0;
      rd_b_q <= '0;
    end else if (clear_s) begin
      wr_a_q <= '0;
      rd_a_q <= '0;
      wr_b_q <= '0;
      rd_b_q <= '0;
    end else if (drain_s) begin
      rd_a_q <= wr_a_q;
      rd_b_q <= wr_b_q;
    end else if (run_pop_s) begin
      rd_a_q <= rd_a_q + 1'b1;
      rd_b_q <= rd_b_q + 1'b1;
    end else if (idle_s) begin
      if (push_a_s && !full_a_s)  wr_a_q <= wr_a_q + 1'b1;
      if (pop_a_s  && !empty_a_s) rd_a_q <= rd_a_q + 1'b1;
      if (push_b_s && !full_b_s)  wr_b_q <= wr_b_q + 1'b1;
      if (pop_b_s  && !empty_b_s) rd_b_q <= rd_b_q + 1'b1;
    end
  end

  // FIFO storage writes (no reset needed on data).
  always_ff @(posedge clk) begin
    if (idle_s && push_a_s && !full_a_s) mem_a_q[wr_a_q[AW-1:0]] <= writedata[DATA_W-1:0];
    if (idle_s && push_b_s && !full_b_s) mem_b_q[wr_b_q[AW-1:0]] <= writedata[DATA_W-1:0];
  end

  assign readdata = readdata_q;
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_string_fifo_cmp_avalon.sv
// Directed self-checking bench for string_fifo_cmp_avalon.
module tb_string_fifo_cmp_avalon;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  string_fifo_cmp_avalon #(.DATA_W(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read),
    .write(write), .address(address), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_done(output logic ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus_read(3'd3, s);
      if (s[0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL reset_status: got %h exp %h", d, 32'h0); n_fail++; end
    n_checks++; if (irq !== 1'b0) begin $display("FAIL reset_irq: got %b exp 0", irq); n_fail++; end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL reset_result: got %h exp %h", d, 32'h0); n_fail++; end
    bus_read(3'd0, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL reset_pop_empty: got %h exp %h", d, 32'h0); n_fail++; end
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h10) begin $display("FAIL reset_udf_a: got %h exp %h", d, 32'h10); n_fail++; end
    bus_read(3'd7, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL reset_unmapped: got %h exp %h", d, 32'h0); n_fail++; end
  endtask

  task automatic test_push_pop;
    logic [31:0] d;
    bus_write(3'd2, 32'h2);
    bus_write(3'd0, 32'h11223344);
    bus_write(3'd0, 32'h55667788);
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h200) begin $display("FAIL pp_level2: got %h exp %h", d, 32'h200); n_fail++; end
    // Manual pop to observe the one-cycle read latency.
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 3'd0;
    #1;
    n_checks++; if (readdata !== 32'h200) begin $display("FAIL pp_latency: got %h exp %h", readdata, 32'h200); n_fail++; end
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    n_checks++; if (readdata !== 32'h11223344) begin $display("FAIL pp_pop1: got %h exp %h", readdata, 32'h11223344); n_fail++; end
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h100) begin $display("FAIL pp_level1: got %h exp %h", d, 32'h100); n_fail++; end
    bus_read(3'd0, d);
    n_checks++; if (d !== 32'h55667788) begin $display("FAIL pp_pop2: got %h exp %h", d, 32'h55667788); n_fail++; end
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL pp_level0: got %h exp %h", d, 32'h0); n_fail++; end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    bus_write(3'd2, 32'h2);
    for (int i = 1; i <= 17; i++) bus_write(3'd0, 32'(i));
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h1004) begin $display("FAIL ovf_status: got %h exp %h", d, 32'h1004); n_fail++; end
    for (int i = 1; i <= 16; i++) begin
      bus_read(3'd0, d);
      n_checks++; if (d !== 32'(i)) begin $display("FAIL ovf_pop%0d: got %h exp %h", i, d, 32'(i)); n_fail++; end
    end
    bus_write(3'd3, 32'h3D);
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL ovf_w1c: got %h exp %h", d, 32'h0); n_fail++; end
  endtask

  task automatic test_compare_mismatch;
    logic [31:0] d;
    logic ok;
    bus_write(3'd2, 32'h2);
    bus_write(3'd0, 32'h48454C4C);  // "HELL"
    bus_write(3'd0, 32'h4F5F574F);  // "O_WO"
    bus_write(3'd1, 32'h48454C4C);  // "HELL"
    bus_write(3'd1, 32'h4F5F584F);  // "O_XO"
    bus_write(3'd2, 32'h4);
    bus_read(3'd2, d);
    n_checks++; if (d !== 32'h4) begin $display("FAIL mm_ctrl_rd: got %h exp %h", d, 32'h4); n_fail++; end
    bus_write(3'd2, 32'h5);
    wait_done(ok);
    n_checks++; if (ok !== 1'b1) begin $display("FAIL mm_timeout: got %b exp 1", ok); n_fail++; end
    n_checks++; if (irq !== 1'b1) begin $display("FAIL mm_irq: got %b exp 1", irq); n_fail++; end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h6) begin $display("FAIL mm_result: got %h exp %h", d, 32'h6); n_fail++; end
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h1) begin $display("FAIL mm_status: got %h exp %h", d, 32'h1); n_fail++; end
    bus_write(3'd3, 32'h1);
    n_checks++; if (irq !== 1'b0) begin $display("FAIL mm_irq_w1c: got %b exp 0", irq); n_fail++; end
  endtask

  task automatic test_compare_short;
    logic [31:0] d;
    logic ok;
    bus_write(3'd2, 32'h2);
    bus_write(3'd0, 32'h01020304);
    bus_write(3'd0, 32'h05060708);
    bus_write(3'd1, 32'h01020304);
    bus_write(3'd2, 32'h1);
    wait_done(ok);
    n_checks++; if (ok !== 1'b1) begin $display("FAIL sh_timeout: got %b exp 1", ok); n_fail++; end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h4) begin $display("FAIL sh_result: got %h exp %h", d, 32'h4); n_fail++; end
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h1) begin $display("FAIL sh_status: got %h exp %h", d, 32'h1); n_fail++; end
    n_checks++; if (irq !== 1'b0) begin $display("FAIL sh_irq_off: got %b exp 0", irq); n_fail++; end
  endtask

  task automatic test_equal_and_abort;
    logic [31:0] d;
    logic ok;
    bus_write(3'd2, 32'h2);
    bus_write(3'd0, 32'hAABBCCDD); bus_write(3'd1, 32'hAABBCCDD);
    bus_write(3'd0, 32'h00000000); bus_write(3'd1, 32'h00000000);
    bus_write(3'd0, 32'hFFFFFFFF); bus_write(3'd1, 32'hFFFFFFFF);
    bus_write(3'd2, 32'h1);
    wait_done(ok);
    n_checks++; if (ok !== 1'b1) begin $display("FAIL eq_timeout: got %b exp 1", ok); n_fail++; end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h8000000C) begin $display("FAIL eq_result: got %h exp %h", d, 32'h8000000C); n_fail++; end
    // Second run aborted by clear+go while still comparing.
    bus_write(3'd2, 32'h2);
    for (int i = 0; i < 3; i++) begin
      bus_write(3'd0, 32'h12345678);
      bus_write(3'd1, 32'h12345678);
    end
    bus_write(3'd2, 32'h1);
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h00020202) begin $display("FAIL ab_busy: got %h exp %h", d, 32'h00020202); n_fail++; end
    bus_write(3'd2, 32'h3);
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL ab_status: got %h exp %h", d, 32'h0); n_fail++; end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h8000000C) begin $display("FAIL ab_result_kept: got %h exp %h", d, 32'h8000000C); n_fail++; end
  endtask

  task automatic test_busy_access;
    logic [31:0] d;
    logic ok;
    bus_write(3'd2, 32'h2);
    for (int i = 0; i < 4; i++) begin
      bus_write(3'd0, 32'hCAFE0000 + 32'(i));
      bus_write(3'd1, 32'hCAFE0000 + 32'(i));
    end
    bus_write(3'd2, 32'h1);
    bus_write(3'd0, 32'hDEADBEEF);
    bus_read(3'd1, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL busy_pop: got %h exp %h", d, 32'h0); n_fail++; end
    wait_done(ok);
    n_checks++; if (ok !== 1'b1) begin $display("FAIL busy_timeout: got %b exp 1", ok); n_fail++; end
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h25) begin $display("FAIL busy_flags: got %h exp %h", d, 32'h25); n_fail++; end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h80000010) begin $display("FAIL busy_result: got %h exp %h", d, 32'h80000010); n_fail++; end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_compare_mismatch();
    test_compare_short();
    test_equal_and_abort();
    test_busy_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
